watch_set_ctrl: RTL and testbench

WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

---
 rtl/watch_pkg.sv | 21 ++
 rtl/bcd60_adjust.sv | 39 +++
 rtl/watch_set_ctrl.sv | 162 ++++++++++++++++
 tb/tb_watch_set_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared encodings and BCD limits for the watch time-setting controller.
// Combinational helpers only; no latency, no flow control.
package watch_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_MIN = 2'b01,
        MODE_SET_SEC = 2'b10,
        MODE_LOAD    = 2'b11
    } mode_e;

    localparam logic [3:0] BCD_ONES_MAX  = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX  = 4'd5;
    localparam int         TIMEOUT_TICKS = 10;
    localparam int         TO_CNT_W      = $clog2(TIMEOUT_TICKS + 1);

    function automatic logic is_bcd59(input logic [3:0] tens, input logic [3:0] ones);
        return (tens == BCD_TENS_MAX) && (ones == BCD_ONES_MAX);
    endfunction

endpackage

// File: rtl/bcd60_adjust.sv
// Combinational +/-1 mod-60 stepper on a two-digit BCD value; inc and dec together hold.
// Zero latency; out-of-range digits are clamped so the result is always legal BCD.
module bcd60_adjust
    import watch_pkg::*;
(
    input  logic [3:0] tens_i,
    input  logic [3:0] ones_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    logic [3:0] tens_c;
    logic [3:0] ones_c;

    always_comb begin
        tens_c = (tens_i > BCD_TENS_MAX) ? BCD_TENS_MAX : tens_i;
        ones_c = (ones_i > BCD_ONES_MAX) ? BCD_ONES_MAX : ones_i;
        tens_o = tens_c;
        ones_o = ones_c;
        if (inc_i && !dec_i) begin
            if (ones_c == BCD_ONES_MAX) begin
                ones_o = 4'd0;
                tens_o = (tens_c == BCD_TENS_MAX) ? 4'd0 : tens_c + 4'd1;
            end else begin
                ones_o = ones_c + 4'd1;
            end
        end else if (dec_i && !inc_i) begin
            if (ones_c == 4'd0) begin
                ones_o = BCD_ONES_MAX;
                tens_o = (tens_c == 4'd0) ? BCD_TENS_MAX : tens_c - 4'd1;
            end else begin
                ones_o = ones_c - 4'd1;
            end
        end
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// Watch run/set controller: gates 1 s ticks to the counters, edits shadow time, loads it back.
// Outputs registered, 1-cycle latency; pulse inputs, no backpressure. Option: WATCH_SET_TIMEOUT_EN.
module watch_set_ctrl
    import watch_pkg::*;
(
    input  logic       clk,
    input  logic       reset_p,
    input  logic       tick_1s,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [3:0] sec1,
    input  logic [3:0] sec10,
    input  logic [3:0] min1,
    input  logic [3:0] min10,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       sec_load,
    output logic       min_load,
    output logic [3:0] set_sec1,
    output logic [3:0] set_sec10,
    output logic [3:0] set_min1,
    output logic [3:0] set_min10,
    output logic [1:0] mode_state
);

    mode_e      mode_q, mode_d;
    logic       sec_tick_q, sec_tick_d;
    logic       min_tick_q, min_tick_d;
    logic       load_q, load_d;
    logic [3:0] smin10_q, smin10_d, smin1_q, smin1_d;
    logic [3:0] ssec10_q, ssec10_d, ssec1_q, ssec1_d;
    logic [3:0] min_adj_tens, min_adj_ones;
    logic [3:0] sec_adj_tens, sec_adj_ones;
    logic       edit_req;

`ifdef WATCH_SET_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_TICKS - 1);
    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
`endif

    bcd60_adjust u_min_adj (
        .tens_i (smin10_q),
        .ones_i (smin1_q),
        .inc_i  (btn_inc),
        .dec_i  (btn_dec),
        .tens_o (min_adj_tens),
        .ones_o (min_adj_ones)
    );

    bcd60_adjust u_sec_adj (
        .tens_i (ssec10_q),
        .ones_i (ssec1_q),
        .inc_i  (btn_inc),
        .dec_i  (btn_dec),
        .tens_o (sec_adj_tens),
        .ones_o (sec_adj_ones)
    );

    // btn_mode pre-empts an edit in the same cycle; simultaneous inc+dec cancels.
    assign edit_req = (btn_inc ^ btn_dec) && !btn_mode;

    always_comb begin
        mode_d   = mode_q;
        smin10_d = smin10_q;
        smin1_d  = smin1_q;
        ssec10_d = ssec10_q;
        ssec1_d  = ssec1_q;

        // A tick that coincides with leaving RUN is dropped so no tick lands in SET_MIN.
        sec_tick_d = (mode_q == MODE_RUN) && tick_1s && !btn_mode;
        min_tick_d = sec_tick_d && is_bcd59(sec10, sec1);

        case (mode_q)
            MODE_RUN: begin
                if (btn_mode) begin
                    mode_d   = MODE_SET_MIN;
                    smin10_d = min10;
                    smin1_d  = min1;
                    ssec10_d = sec10;
                    ssec1_d  = sec1;
                end
            end
            MODE_SET_MIN: begin
                if (btn_mode) begin
                    mode_d = MODE_SET_SEC;
                end else if (edit_req) begin
                    smin10_d = min_adj_tens;
                    smin1_d  = min_adj_ones;
                end
            end
            MODE_SET_SEC: begin
                if (btn_mode) begin
                    mode_d = MODE_LOAD;
                end else if (edit_req) begin
                    ssec10_d = sec_adj_tens;
                    ssec1_d  = sec_adj_ones;
                end
            end
            default: mode_d = MODE_RUN;
        endcase

`ifdef WATCH_SET_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        if ((mode_q == MODE_SET_MIN) || (mode_q == MODE_SET_SEC)) begin
            if (btn_mode || btn_inc || btn_dec) begin
                to_cnt_d = '0;
            end else if (tick_1s) begin
                if (to_cnt_q == TO_LAST) begin
                    to_cnt_d = '0;
                    mode_d   = MODE_RUN;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
        end else begin
            to_cnt_d = '0;
        end
`endif

        load_d = (mode_d == MODE_LOAD);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            mode_q     <= MODE_RUN;
            sec_tick_q <= 1'b0;
            min_tick_q <= 1'b0;
            load_q     <= 1'b0;
            smin10_q   <= 4'd0;
            smin1_q    <= 4'd0;
            ssec10_q   <= 4'd0;
            ssec1_q    <= 4'd0;
`ifdef WATCH_SET_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            mode_q     <= mode_d;
            sec_tick_q <= sec_tick_d;
            min_tick_q <= min_tick_d;
            load_q     <= load_d;
            smin10_q   <= smin10_d;
            smin1_q    <= smin1_d;
            ssec10_q   <= ssec10_d;
            ssec1_q    <= ssec1_d;
`ifdef WATCH_SET_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    assign sec_tick   = sec_tick_q;
    assign min_tick   = min_tick_q;
    assign sec_load   = load_q;
    assign min_load   = load_q;
    assign set_sec1   = ssec1_q;
    assign set_sec10  = ssec10_q;
    assign set_min1   = smin1_q;
    assign set_min10  = smin10_q;
    assign mode_state = mode_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed plus random bench for watch_set_ctrl against an integer-valued mod-60 model.
module tb_watch_set_ctrl;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       tick_1s, btn_mode, btn_inc, btn_dec;
    logic [3:0] sec1, sec10, min1, min10;
    logic       sec_tick, min_tick, sec_load, min_load;
    logic [3:0] set_sec1, set_sec10, set_min1, set_min10;
    logic [1:0] mode_state;

    int total = 0;
    int bad   = 0;

    // reference model: state as 0..3, shadows as plain integers 0..59
    int m_state, m_smin, m_ssec, m_to;
    bit m_stick, m_mtick;

    always #5 clk = ~clk;

    watch_set_ctrl dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .tick_1s    (tick_1s),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .sec1       (sec1),
        .sec10      (sec10),
        .min1       (min1),
        .min10      (min10),
        .sec_tick   (sec_tick),
        .min_tick   (min_tick),
        .sec_load   (sec_load),
        .min_load   (min_load),
        .set_sec1   (set_sec1),
        .set_sec10  (set_sec10),
        .set_min1   (set_min1),
        .set_min10  (set_min10),
        .mode_state (mode_state)
    );

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cnt(input int s, input int m);
        sec1  = 4'(s % 10);
        sec10 = 4'(s / 10);
        min1  = 4'(m % 10);
        min10 = 4'(m / 10);
    endtask

    task automatic model_reset();
        m_state = 0; m_smin = 0; m_ssec = 0; m_to = 0;
        m_stick = 0; m_mtick = 0;
    endtask

    task automatic model_step(input bit mo, input bit in, input bit de, input bit tk);
        int cur_sec, ns;
        cur_sec = sec10 * 10 + sec1;
        m_stick = (m_state == 0) && tk && !mo;
        m_mtick = m_stick && (cur_sec == 59);
        ns = m_state;
        case (m_state)
            0: if (mo) begin
                   ns = 1;
                   m_smin = min10 * 10 + min1;
                   m_ssec = cur_sec;
               end
            1: if (mo) ns = 2;
               else if (in != de) m_smin = (m_smin + (in ? 1 : 59)) % 60;
            2: if (mo) ns = 3;
               else if (in != de) m_ssec = (m_ssec + (in ? 1 : 59)) % 60;
            default: ns = 0;
        endcase
`ifdef WATCH_SET_TIMEOUT_EN
        if (m_state == 1 || m_state == 2) begin
            if (mo || in || de) m_to = 0;
            else if (tk) begin
                m_to++;
                if (m_to == 10) begin
                    m_to = 0;
                    ns = 0;
                end
            end
        end else begin
            m_to = 0;
        end
`endif
        m_state = ns;
    endtask

    task automatic check_all();
        chk("mode_state", 8'(mode_state), 8'(m_state));
        chk("sec_tick", 8'(sec_tick), 8'(m_stick));
        chk("min_tick", 8'(min_tick), 8'(m_mtick));
        chk("sec_load", 8'(sec_load), 8'(m_state == 3));
        chk("min_load", 8'(min_load), 8'(m_state == 3));
        chk("set_min", {set_min10, set_min1}, to_bcd(m_smin));
        chk("set_sec", {set_sec10, set_sec1}, to_bcd(m_ssec));
    endtask

    task automatic step(input bit mo, input bit in, input bit de, input bit tk);
        @(negedge clk);
        btn_mode = mo; btn_inc = in; btn_dec = de; tick_1s = tk;
        model_step(mo, in, de, tk);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mode"}, 8'(mode_state), 8'd0);
        chk({tag, "_ticks"}, {6'd0, sec_tick, min_tick}, 8'd0);
        chk({tag, "_loads"}, {6'd0, sec_load, min_load}, 8'd0);
        chk({tag, "_set_min"}, {set_min10, set_min1}, 8'h00);
        chk({tag, "_set_sec"}, {set_sec10, set_sec1}, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_p = 1'b1;
        tick_1s = 0; btn_mode = 0; btn_inc = 0; btn_dec = 0;
        set_cnt(0, 0);
        model_reset();
        #2;
        check_zero("reset");
        @(negedge clk);
        reset_p = 1'b0;
        step(0, 0, 0, 0);

        // 12:59 plus a tick in RUN: both count enables on the next cycle only
        set_cnt(59, 12);
        step(0, 0, 0, 1);
        chk("rollover_sec_tick", 8'(sec_tick), 8'd1);
        chk("rollover_min_tick", 8'(min_tick), 8'd1);
        step(0, 0, 0, 0);
        chk("rollover_after", {6'd0, sec_tick, min_tick}, 8'd0);

        // edit minutes from 34:07 down three steps
        set_cnt(7, 34);
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        chk("edit_set_min", {set_min10, set_min1}, 8'h31);
        chk("edit_mode", 8'(mode_state), 8'h01);
        chk("edit_no_tick", 8'(sec_tick), 8'd0);

        // seconds: walk to 00, wrap down to 59 and back up to 00
        step(1, 0, 0, 0);
        repeat (7) step(0, 0, 1, 0);
        chk("sec_at_00", {set_sec10, set_sec1}, 8'h00);
        step(0, 0, 1, 0);
        chk("sec_wrap_dn", {set_sec10, set_sec1}, 8'h59);
        step(0, 1, 0, 0);
        chk("sec_wrap_up", {set_sec10, set_sec1}, 8'h00);

        // load cycle then back to RUN
        step(1, 0, 0, 1);
        chk("load_mode", 8'(mode_state), 8'h03);
        chk("load_strobes", {6'd0, sec_load, min_load}, 8'h03);
        chk("load_set_min", {set_min10, set_min1}, 8'h31);
        step(1, 1, 0, 0);
        chk("after_load_mode", 8'(mode_state), 8'h00);
        chk("after_load_strobes", {6'd0, sec_load, min_load}, 8'h00);

        // conflicting buttons
        set_cnt(45, 20);
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        chk("incdec_same", {set_min10, set_min1}, 8'h20);
        step(1, 1, 0, 0);
        chk("mode_wins_state", 8'(mode_state), 8'h02);
        chk("mode_wins_min", {set_min10, set_min1}, 8'h20);
        step(1, 0, 1, 0);
        chk("mode_wins_sec", {set_sec10, set_sec1}, 8'h45);
        step(0, 0, 0, 0);

        // asynchronous reset in the middle of an edit
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        #2;
        reset_p = 1'b1;
        #1;
        check_zero("mid_edit_reset");
        @(negedge clk);
        reset_p = 1'b0;
        model_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

`ifdef WATCH_SET_TIMEOUT_EN
        set_cnt(30, 10);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (9) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
        chk("timeout_pre", 8'(mode_state), 8'h02);
        step(0, 0, 0, 1);
        chk("timeout_mode", 8'(mode_state), 8'h00);
        chk("timeout_no_load", {6'd0, sec_load, min_load}, 8'h00);
        step(0, 0, 0, 0);
`endif

        // random phase against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0)
                set_cnt($urandom_range(0, 59), $urandom_range(0, 59));
            else if ($urandom_range(0, 7) == 0)
                set_cnt(59, $urandom_range(0, 59));
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end

        @(negedge clk);
        tick_1s = 0; btn_mode = 0; btn_inc = 0; btn_dec = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
